dist_writeback_scoreboard: RTL and testbench
============================================

# dist_writeback_scoreboard

Tracks in-flight distribution-register writes from the multi-cycle distribution arithmetic unit and retires them into the distribution register file. It sits between EX, which issues distribution ops, and the distribution register file write port; it is the producing end of the distribution-register hazard path. Its per-register busy bits stall ID whenever a source distribution register has an outstanding write that the forwarding path cannot yet supply. Results arrive out of order, are buffered in a small FIFO, and drain one per granted cycle.

## Interface
- ADDR_W, 5, distribution register address width (32 registers).
- DATA_W, 32, distribution word width.
- DEPTH, 4, result FIFO depth; also the maximum number of outstanding issues (power of two, ≥2).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  EX is issuing a distribution op.
- iss_addr  in  ADDR_W  destination distribution register of the issuing op.
- iss_ready  out  1  issue accepted this cycle when high with iss_valid.
- res_valid  in  1  distribution unit presents a result.
- res_addr  in  ADDR_W  destination of the result.
- res_data  in  DATA_W  result word.
- res_ready  out  1  result accepted this cycle when high with res_valid.
- wb_grant  in  1  the register file write port is free for this block this cycle.
- wb_en  out  1  write strobe to the distribution register file.
- wb_addr  out  ADDR_W  write address.
- wb_data  out  DATA_W  write data.
- id_src_addr  in  ADDR_W  distribution source address in ID.
- id_stall  out  1  ID must hold.
- res_err  out  1  sticky: a result arrived for a non-busy register.

## Operation
- State: busy[2^ADDR_W-1:0]; outstanding counter (0..DEPTH, width clog2(DEPTH)+1); FIFO of {addr, data}, DEPTH entries, with read/write pointers that carry a wrap bit.
- Issue is accepted when iss_valid && iss_ready. iss_ready = !busy[iss_addr] && outstanding < DEPTH. iss_ready is low on a write-after-write to a busy address.
- Address 0: iss_ready = 1 at address 0. An issue to address 0 is never marked busy and does not change outstanding.
- On accept (address ≠ 0): busy[iss_addr] is set and outstanding increments, both at the next edge.
- res_ready = FIFO not full.
- On a result handshake:
  - If res_addr is busy, push {res_addr, res_data}.
  - If res_addr = 0, drop the result silently.
  - If res_addr is non-busy and non-zero, drop the result and set res_err.
- Writeback: wb_en = FIFO non-empty && wb_grant. wb_addr and wb_data come from the FIFO head (combinational). On wb_en, pop the entry, clear busy[wb_addr] and decrement outstanding at the edge.
- Simultaneous issue accept and writeback: outstanding is unchanged.
- Simultaneous push and pop on a full FIFO: res_ready is low while full, so no push occurs. Push and pop together on a non-full FIFO are both performed.
- id_stall = (id_src_addr ≠ 0) && (busy[id_src_addr] || (iss_valid && iss_ready && iss_addr == id_src_addr)).
- Stall remains asserted during the writeback cycle itself; it drops the cycle after.
- Reset mid-operation:
  - Busy bits, outstanding and FIFO contents are discarded.
  - res_err is cleared.
  - In-flight results arriving after reset report res_err.

## Timing
- Reset values:
  - iss_ready = 1 when no issue is pending.
  - res_ready = 1.
  - wb_en = 0; wb_addr = 0; wb_data = 0 (FIFO empty).
  - id_stall = 0.
  - res_err = 0.
- Issue-to-busy latency: 1 cycle. The same-cycle stall is covered by the combinational issue term.
- Result-to-write latency: a result pushed at edge N is written at the earliest in cycle N+1, if wb_grant is high and it is at the head.
- Throughput: one writeback per cycle; one issue per cycle.
- All outputs except res_err, busy-derived terms and FIFO head are combinational from inputs plus state. There is no combinational path from res_valid to wb_en.

## Test plan
- Reset → iss_ready=1, res_ready=1, wb_en=0, id_stall=0, res_err=0. Hold res_valid=1, addr=3 → res_err=1 next cycle, no wb.
- Issue r5 at cycle 0 with id_src=5:
  - Cycle 0: id_stall=1.
  - Result r5 = 0xA5A5A5A5 at cycle 3 with wb_grant=1: wb_en=1, wb_addr=5, wb_data=0xA5A5A5A5 in cycle 4.
  - Cycle 4: id_stall=1. Cycle 5: id_stall=0.
- Issue r7, then re-issue r7 → iss_ready=0 until r7's writeback edge; re-issue accepted the following cycle.
- Issue r1..r4 (DEPTH=4) → fifth issue to r6 sees iss_ready=0. Results returned r3, r1, r4, r2 with wb_grant=0 → FIFO full, res_ready=0. Raise wb_grant → writes in order 3, 1, 4, 2 on consecutive cycles; outstanding returns to 0.
- Issue r0 → iss_ready=1, id_stall=0 for id_src=0, no busy set. Result to r0 is dropped; res_err stays 0.
- Assert rst_n=0 with 2 entries queued and busy r9 → all outputs at reset values asynchronously. After release, a result for r9 sets res_err.

Source files
------------

// File: rtl/dist_writeback_scoreboard_if.sv
// Handshake bundle between EX/ID, the distribution unit, the register-file write port
// and the writeback scoreboard.
interface dist_writeback_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              wb_grant;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] id_src_addr;
  logic              id_stall;
  logic              res_err;

  modport master (
    output iss_valid, iss_addr, res_valid, res_addr, res_data, wb_grant, id_src_addr,
    input  iss_ready, res_ready, wb_en, wb_addr, wb_data, id_stall, res_err
  );

  modport slave (
    input  iss_valid, iss_addr, res_valid, res_addr, res_data, wb_grant, id_src_addr,
    output iss_ready, res_ready, wb_en, wb_addr, wb_data, id_stall, res_err
  );
endinterface

// File: rtl/dist_writeback_scoreboard.sv
// Tracks outstanding distribution-register writes, buffers out-of-order results in a
// small FIFO and retires them one per granted cycle into the register file.
module dist_writeback_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dist_writeback_scoreboard_if.slave   io_sb
);
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int CNT_W    = IDX_W + 1;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [CNT_W-1:0]    r_outstanding;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [DEPTH];
  logic                r_res_err;

  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_iss_addr_zero;
  logic                w_iss_ready;
  logic                w_iss_fire;
  logic                w_res_fire;
  logic                w_res_busy;
  logic                w_push;
  logic                w_res_bad;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                        (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

  assign w_iss_addr_zero = (io_sb.iss_addr == '0);
  assign w_iss_ready     = w_iss_addr_zero ||
                           (!r_busy[io_sb.iss_addr] && (r_outstanding < CNT_W'(DEPTH)));
  assign w_iss_fire      = io_sb.iss_valid && w_iss_ready && !w_iss_addr_zero;

  assign w_res_fire = io_sb.res_valid && !w_fifo_full;
  assign w_res_busy = r_busy[io_sb.res_addr];
  assign w_push     = w_res_fire && w_res_busy;
  assign w_res_bad  = w_res_fire && !w_res_busy && (io_sb.res_addr != '0);

  assign w_head_addr = r_fifo_addr[r_rd_ptr[IDX_W-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[IDX_W-1:0]];
  assign w_pop       = !w_fifo_empty && io_sb.wb_grant;

  // Register 0 is hardwired and never tracked.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_busy_next[gi] =
          (w_iss_fire && (io_sb.iss_addr == ADDR_W'(gi))) ||
          (r_busy[gi] && !(w_pop && (w_head_addr == ADDR_W'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= '0;
      r_outstanding <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_res_err     <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      case ({w_iss_fire, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_res_bad) r_res_err <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[IDX_W-1:0]] <= io_sb.res_addr;
      r_fifo_data[r_wr_ptr[IDX_W-1:0]] <= io_sb.res_data;
    end
  end

  assign io_sb.iss_ready = w_iss_ready;
  assign io_sb.res_ready = !w_fifo_full;
  assign io_sb.wb_en     = w_pop;
  assign io_sb.wb_addr   = w_fifo_empty ? '0 : w_head_addr;
  assign io_sb.wb_data   = w_fifo_empty ? '0 : w_head_data;
  assign io_sb.res_err   = r_res_err;

  // The same-cycle issue term covers the edge before the busy bit is visible.
  assign io_sb.id_stall  = (io_sb.id_src_addr != '0) &&
                           (r_busy[io_sb.id_src_addr] ||
                            (io_sb.iss_valid && w_iss_ready &&
                             (io_sb.iss_addr == io_sb.id_src_addr)));
endmodule

// File: tb/tb_dist_writeback_scoreboard.sv
// Directed bench for dist_writeback_scoreboard: issue/result/writeback sequences,
// write-after-write blocking, FIFO full, address 0 and asynchronous reset.
module tb_dist_writeback_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dist_writeback_scoreboard_if #(.ADDR_W(AW), .DATA_W(DW)) sb_if ();

  dist_writeback_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_sb (sb_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic iss(input logic v, input logic [AW-1:0] a);
    sb_if.iss_valid = v;
    sb_if.iss_addr  = a;
  endtask

  task automatic res(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb_if.res_valid = v;
    sb_if.res_addr  = a;
    sb_if.res_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    iss(1'b0, '0);
    res(1'b0, '0, '0);
    sb_if.wb_grant    = 1'b0;
    sb_if.id_src_addr = '0;
    #1;
    // Reset values
    chk("rst_iss_ready", sb_if.iss_ready, 1);
    chk("rst_res_ready", sb_if.res_ready, 1);
    chk("rst_wb_en", sb_if.wb_en, 0);
    chk("rst_wb_addr", sb_if.wb_addr, 0);
    chk("rst_wb_data", sb_if.wb_data, 0);
    chk("rst_id_stall", sb_if.id_stall, 0);
    chk("rst_res_err", sb_if.res_err, 0);
    sb_if.iss_addr = 5'd5;
    #1;
    chk("rst_iss_ready_r5", sb_if.iss_ready, 1);
    sb_if.iss_addr = '0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Result to non-busy r3 sets sticky error, no writeback
    res(1'b1, 5'd3, 32'h123);
    sb_if.wb_grant = 1'b1;
    mid();
    chk("t1_res_ready", sb_if.res_ready, 1);
    chk("t1_err_before", sb_if.res_err, 0);
    cyc();
    mid();
    chk("t1_err_after", sb_if.res_err, 1);
    chk("t1_no_wb", sb_if.wb_en, 0);
    res(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_err_cleared", sb_if.res_err, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Issue r5 with id_src=5; result at cycle 3, writeback cycle 4
    iss(1'b1, 5'd5);
    sb_if.id_src_addr = 5'd5;
    mid();
    chk("t2_iss_ready", sb_if.iss_ready, 1);
    chk("t2_stall_c0", sb_if.id_stall, 1);
    cyc();
    iss(1'b0, '0);
    mid();
    chk("t2_stall_c1", sb_if.id_stall, 1);
    cyc();
    cyc();
    res(1'b1, 5'd5, 32'hA5A5_A5A5);
    mid();
    chk("t2_res_ready_c3", sb_if.res_ready, 1);
    chk("t2_no_wb_c3", sb_if.wb_en, 0);
    cyc();
    res(1'b0, '0, '0);
    mid();
    chk("t2_wb_en_c4", sb_if.wb_en, 1);
    chk("t2_wb_addr_c4", sb_if.wb_addr, 5);
    chk("t2_wb_data_c4", sb_if.wb_data, 32'hA5A5_A5A5);
    chk("t2_stall_c4", sb_if.id_stall, 1);
    cyc();
    mid();
    chk("t2_wb_en_c5", sb_if.wb_en, 0);
    chk("t2_stall_c5", sb_if.id_stall, 0);
    sb_if.id_src_addr = '0;
    cyc();

    // Write-after-write on r7
    iss(1'b1, 5'd7);
    mid();
    chk("t3_first_ready", sb_if.iss_ready, 1);
    cyc();
    res(1'b1, 5'd7, 32'h77);
    mid();
    chk("t3_waw_ready_c1", sb_if.iss_ready, 0);
    cyc();
    res(1'b0, '0, '0);
    mid();
    chk("t3_wb_en_c2", sb_if.wb_en, 1);
    chk("t3_wb_addr_c2", sb_if.wb_addr, 7);
    chk("t3_waw_ready_c2", sb_if.iss_ready, 0);
    cyc();
    mid();
    chk("t3_reissue_ready_c3", sb_if.iss_ready, 1);
    cyc();
    iss(1'b0, 5'd7);
    sb_if.id_src_addr = 5'd7;
    res(1'b1, 5'd7, 32'h78);
    mid();
    chk("t3_stall_reissued", sb_if.id_stall, 1);
    chk("t3_ready_busy", sb_if.iss_ready, 0);
    cyc();
    res(1'b0, '0, '0);
    mid();
    chk("t3_wb2_data", sb_if.wb_data, 32'h78);
    cyc();
    mid();
    chk("t3_stall_clear", sb_if.id_stall, 0);
    sb_if.id_src_addr = '0;
    sb_if.wb_grant = 1'b0;
    cyc();

    // Fill to DEPTH outstanding, return out of order, then drain
    for (int i = 1; i <= 4; i++) begin
      iss(1'b1, 5'(i));
      mid();
      chk($sformatf("t4_iss_ready_r%0d", i), sb_if.iss_ready, 1);
      cyc();
    end
    iss(1'b1, 5'd6);
    mid();
    chk("t4_iss_ready_r6_full", sb_if.iss_ready, 0);
    cyc();
    iss(1'b0, 5'd6);
    res(1'b1, 5'd3, 32'h103);
    mid(); chk("t4_res_ready_r3", sb_if.res_ready, 1); cyc();
    res(1'b1, 5'd1, 32'h101);
    mid(); chk("t4_res_ready_r1", sb_if.res_ready, 1); cyc();
    res(1'b1, 5'd4, 32'h104);
    mid(); chk("t4_res_ready_r4", sb_if.res_ready, 1); cyc();
    res(1'b1, 5'd2, 32'h102);
    mid(); chk("t4_res_ready_r2", sb_if.res_ready, 1); cyc();
    res(1'b0, '0, '0);
    mid();
    chk("t4_full_res_ready", sb_if.res_ready, 0);
    chk("t4_no_grant_wb_en", sb_if.wb_en, 0);
    chk("t4_head_addr", sb_if.wb_addr, 3);
    cyc();
    sb_if.wb_grant = 1'b1;
    mid();
    chk("t4_wb0_en", sb_if.wb_en, 1);
    chk("t4_wb0_addr", sb_if.wb_addr, 3);
    chk("t4_wb0_data", sb_if.wb_data, 32'h103);
    chk("t4_wb0_res_ready", sb_if.res_ready, 0);
    cyc();
    mid();
    chk("t4_wb1_addr", sb_if.wb_addr, 1);
    chk("t4_wb1_data", sb_if.wb_data, 32'h101);
    chk("t4_wb1_res_ready", sb_if.res_ready, 1);
    cyc();
    mid();
    chk("t4_wb2_addr", sb_if.wb_addr, 4);
    chk("t4_wb2_data", sb_if.wb_data, 32'h104);
    cyc();
    mid();
    chk("t4_wb3_addr", sb_if.wb_addr, 2);
    chk("t4_wb3_en", sb_if.wb_en, 1);
    cyc();
    mid();
    chk("t4_drained_wb_en", sb_if.wb_en, 0);
    chk("t4_drained_iss_ready_r6", sb_if.iss_ready, 1);
    sb_if.wb_grant = 1'b0;
    cyc();

    // Address 0: accepted, untracked, results dropped silently
    iss(1'b1, 5'd0);
    sb_if.id_src_addr = '0;
    mid();
    chk("t5_r0_ready", sb_if.iss_ready, 1);
    chk("t5_r0_stall", sb_if.id_stall, 0);
    cyc();
    iss(1'b1, 5'd9);  cyc();
    iss(1'b1, 5'd10); cyc();
    iss(1'b1, 5'd11); cyc();
    iss(1'b1, 5'd0);
    mid();
    chk("t5_r0_ready_again", sb_if.iss_ready, 1);
    cyc();
    iss(1'b0, 5'd12);
    res(1'b1, 5'd0, 32'hDEAD);
    mid();
    chk("t5_outstanding_3_ready", sb_if.iss_ready, 1);
    chk("t5_r0_res_ready", sb_if.res_ready, 1);
    cyc();
    res(1'b0, '0, '0);
    sb_if.wb_grant = 1'b1;
    mid();
    chk("t5_r0_no_err", sb_if.res_err, 0);
    chk("t5_r0_no_wb", sb_if.wb_en, 0);
    sb_if.wb_grant = 1'b0;
    cyc();

    // Two entries queued, r9 busy, then asynchronous reset
    res(1'b1, 5'd10, 32'h10A); cyc();
    res(1'b1, 5'd11, 32'h10B); cyc();
    res(1'b0, '0, '0);
    sb_if.id_src_addr = 5'd9;
    iss(1'b0, 5'd9);
    sb_if.wb_grant = 1'b1;
    mid();
    chk("t6_pre_wb_en", sb_if.wb_en, 1);
    chk("t6_pre_wb_addr", sb_if.wb_addr, 10);
    chk("t6_pre_stall_r9", sb_if.id_stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wb_en", sb_if.wb_en, 0);
    chk("t6_rst_wb_addr", sb_if.wb_addr, 0);
    chk("t6_rst_wb_data", sb_if.wb_data, 0);
    chk("t6_rst_stall", sb_if.id_stall, 0);
    chk("t6_rst_iss_ready", sb_if.iss_ready, 1);
    chk("t6_rst_res_ready", sb_if.res_ready, 1);
    chk("t6_rst_res_err", sb_if.res_err, 0);
    cyc();
    rst_n = 1'b1;
    res(1'b1, 5'd9, 32'h99);
    mid();
    chk("t6_late_err_before", sb_if.res_err, 0);
    cyc();
    res(1'b0, '0, '0);
    mid();
    chk("t6_late_err_after", sb_if.res_err, 1);
    chk("t6_late_no_wb", sb_if.wb_en, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
